pattern_seq_detect: RTL and testbench
=====================================

PATTERN_SEQ_DETECT -- requirements
Module: pattern_seq_detect

Interface
REQ-001 Parameter MAX_W, default 4: maximum pattern length in bits (2..32).
REQ-002 Parameter CNT_W, default 16: match-counter width.
REQ-003 Parameter DEF_PATTERN, default 4'b1011 (MAX_W bits): pattern loaded at reset.
REQ-004 Parameter DEF_LEN, default 4: pattern length loaded at reset.
REQ-005 Parameter DEF_OVERLAP, default 1: overlap mode loaded at reset.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 valid  input  1  qualifies in; a bit is consumed only when valid=1.
REQ-009 in  input  1  serial data bit, MSB of pattern arrives first.
REQ-010 cfg_we  input  1  one-cycle strobe loading cfg_pattern/cfg_len/cfg_overlap.
REQ-011 cfg_pattern  input  MAX_W  new pattern, right-aligned (bit 0 = last bit received).
REQ-012 cfg_len  input  $clog2(MAX_W+1)  new active length.
REQ-013 cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-014 out  output  1  Mealy match pulse, combinational from valid/in and registered state.
REQ-015 count  output  CNT_W  number of matches since reset or last cfg_we (only with macro, see Configuration).

Function
REQ-016 History register hist (MAX_W-1 bits) SHALL shift left, inserting in, on every clock with valid=1 and cfg_we=0.
REQ-017 FSM states SHALL be S_FILL (fewer than len-1 bits held) and S_RUN (at least len-1 bits held); fill counter saturates at len-1.
REQ-018 out SHALL be 1 iff valid=1, cfg_we=0, state is S_RUN, and {hist,in} low len bits equal pattern low len bits; otherwise 0.
REQ-019 len=1 SHALL enter S_RUN immediately (no fill), so every matching valid bit asserts out.
REQ-020 cfg_len of 0 or greater than MAX_W SHALL be clamped to MAX_W.
REQ-021 Overlap=1: after a match, hist keeps shifting normally; trailing bits may start the next match.
REQ-022 Overlap=0: on the match cycle, hist and fill counter SHALL clear and the FSM SHALL return to S_FILL; the next match needs len fresh bits.
REQ-023 valid=0 cycles SHALL hold hist, fill counter and state unchanged; out=0.
REQ-024 cfg_we=1 SHALL load the configuration, clear hist, fill counter and count, enter S_FILL, and drop any simultaneous valid bit (out=0 that cycle).
REQ-025 The new configuration SHALL take effect from the cycle after cfg_we.

Reset
REQ-026 rst=1 SHALL asynchronously set pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, hist=0, fill counter=0, state=S_FILL, count=0.
REQ-027 out SHALL be 0 while rst=1; reset mid-stream discards all partial history.
REQ-028 After rst deasserts, detection SHALL restart on the first valid bit.

Configuration
REQ-029 Macro PATSEQ_COUNT_EN: when defined, count port exists and increments by 1 on each out=1 cycle, saturating at 2^CNT_W-1.
REQ-030 Without PATSEQ_COUNT_EN: count port and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package pattern_seq_pkg SHALL hold the state enum (S_FILL, S_RUN), default pattern/length constants and the len-clamp function.
REQ-032 One sub-module pattern_seq_cmp SHALL implement the masked len-bit compare of {hist,in} against pattern (combinational).

Verification
REQ-033 Defaults, overlap=1, valid=1, stream 1,0,1,1,0,1,1 -> out=1 on bits 4 and 7 only; count=2.
REQ-034 cfg_overlap=0, same stream -> out=1 on bit 4 only; stream 1011 1011 -> out on bits 4 and 8; count=2.
REQ-035 Stream 1,0,1,1 with valid=0 for 3 cycles between bits 2 and 3 -> single out on bit 4; out=0 during gaps.
REQ-036 cfg_we with pattern=3'b101, len=3, overlap=1 concurrent with valid=1,in=1 -> that bit dropped, count=0; then 1,0,1,0,1 -> out on bits 3 and 5.
REQ-037 Feed 1,0,1 then assert rst for 1 cycle, then 1 -> no out; then 0,1,1 -> out on last bit; cfg_len=0 -> behaves as len=4.
REQ-038 CNT_W=2, repeating 1011 overlap=0 for 5 matches -> count reaches 3 and holds at 3.

Source files
------------

// File: rtl/pattern_seq_pkg.sv
// Shared types and constants for the serial pattern detector.
package pattern_seq_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [3:0]  DEF_PATTERN_C = 4'b1011;
    localparam int unsigned DEF_LEN_C     = 4;
    localparam bit          DEF_OVERLAP_C = 1'b1;

    // A length of zero or beyond the register width selects the full width.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_w);
        return ((len == 0) || (len > max_w)) ? max_w : len;
    endfunction

endpackage

// File: rtl/pattern_seq_cmp.sv
// Masked compare of the newest len bits of {hist,in} against the pattern.
module pattern_seq_cmp #(
    parameter int unsigned MAX_W = 4,
    parameter int unsigned LEN_W = $clog2(MAX_W + 1)
) (
    input  logic [MAX_W-2:0] hist,
    input  logic             in,
    input  logic [MAX_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             eq_c
);

    logic [MAX_W-1:0] mask;

    // Enable only the low len bit positions, then compare under that mask.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            mask[i] = (i < 32'(len));
        end
        eq_c = ((({hist, in}) ^ pattern) & mask) == '0;
    end

endmodule

// File: rtl/pattern_seq_detect.sv
// Serial pattern detector with runtime-loadable pattern, length and overlap mode.
// Optional match counter when PATSEQ_COUNT_EN is defined.
module pattern_seq_detect
    import pattern_seq_pkg::*;
#(
    parameter int unsigned          MAX_W       = 4,
    parameter int unsigned          CNT_W       = 16,
    parameter logic [MAX_W-1:0]     DEF_PATTERN = MAX_W'(DEF_PATTERN_C),
    parameter int unsigned          DEF_LEN     = DEF_LEN_C,
    parameter bit                   DEF_OVERLAP = DEF_OVERLAP_C,
    localparam int unsigned         LEN_W       = $clog2(MAX_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             in,
    input  logic             cfg_we,
    input  logic [MAX_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             out
`ifdef PATSEQ_COUNT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    localparam int unsigned HW = MAX_W - 1;

    logic [MAX_W-1:0] pattern_r;
    logic [LEN_W-1:0] len_r;
    logic             overlap_r;
    logic [HW-1:0]    hist_r;
    logic [LEN_W-1:0] fill_r;
    state_t           state_r;

    logic [LEN_W-1:0] len_m1_c;
    logic             run_c;
    logic             take_c;
    logic             eq_c;

    // A single-bit pattern needs no history, so it is always ready to match.
    assign len_m1_c = len_r - LEN_W'(1);
    assign run_c    = (state_r == S_RUN) || (len_r == LEN_W'(1));
    assign take_c   = valid && !cfg_we;
    assign out      = !rst && take_c && run_c && eq_c;

    pattern_seq_cmp #(
        .MAX_W (MAX_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .hist    (hist_r),
        .in      (in),
        .pattern (pattern_r),
        .len     (len_r),
        .eq_c    (eq_c)
    );

    // Configuration, history shift and fill-tracking FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_r <= DEF_PATTERN;
            len_r     <= LEN_W'(clamp_len(DEF_LEN, MAX_W));
            overlap_r <= DEF_OVERLAP;
            hist_r    <= '0;
            fill_r    <= '0;
            state_r   <= S_FILL;
        end else if (cfg_we) begin
            pattern_r <= cfg_pattern;
            len_r     <= LEN_W'(clamp_len(32'(cfg_len), MAX_W));
            overlap_r <= cfg_overlap;
            hist_r    <= '0;
            fill_r    <= '0;
            state_r   <= S_FILL;
        end else if (valid) begin
            if (out && !overlap_r) begin
                hist_r  <= '0;
                fill_r  <= '0;
                state_r <= S_FILL;
            end else begin
                hist_r <= HW'({hist_r, in});
                if (fill_r < len_m1_c) begin
                    fill_r <= fill_r + LEN_W'(1);
                end
                state_r <= ((fill_r + LEN_W'(1)) >= len_m1_c) ? S_RUN : S_FILL;
            end
        end
    end

`ifdef PATSEQ_COUNT_EN
    // Saturating match counter, cleared by reconfiguration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (cfg_we) begin
            count <= '0;
        end else if (out && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pattern_seq_detect.sv
// Randomized self-checking bench for pattern_seq_detect against a queue-based model.
module tb_pattern_seq_detect;

    localparam int unsigned MAX_W = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned LEN_W = $clog2(MAX_W + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic             in;
    logic             cfg_we;
    logic [MAX_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             out;
`ifdef PATSEQ_COUNT_EN
    logic [CNT_W-1:0] count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: received bits since the last clear, newest at the back.
    logic [MAX_W-1:0] m_pat;
    int unsigned      m_len;
    bit               m_ovl;
    bit               m_q[$];
    int unsigned      m_cnt;

    always #5 clk = ~clk;

    pattern_seq_detect #(
        .MAX_W (MAX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .in          (in),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .out         (out)
`ifdef PATSEQ_COUNT_EN
        ,
        .count       (count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat = 4'b1011;
        m_len = 4;
        m_ovl = 1'b1;
        m_q.delete();
        m_cnt = 0;
    endtask

    function automatic bit model_out(input bit v, input bit b, input bit we);
        int unsigned n;
        if (!v || we) return 1'b0;
        n = m_q.size() + 1;
        if (n < m_len) return 1'b0;
        for (int unsigned k = 0; k < m_len; k++) begin
            bit x;
            x = (k == 0) ? b : m_q[m_q.size() - k];
            if (x != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input bit v, input bit b, input bit we,
                              input logic [MAX_W-1:0] p, input int unsigned l, input bit o);
        bit hit;
        hit = model_out(v, b, we);
        if (we) begin
            m_pat = p;
            m_len = (l == 0 || l > MAX_W) ? MAX_W : l;
            m_ovl = o;
            m_q.delete();
            m_cnt = 0;
        end else if (v) begin
            if (hit && m_cnt < (2**CNT_W - 1)) m_cnt++;
            if (hit && !m_ovl) m_q.delete();
            else m_q.push_back(b);
            while (m_q.size() > 2 * MAX_W) void'(m_q.pop_front());
        end
    endtask

    // One clock: drive at negedge, check Mealy out before the edge, update model at the edge.
    task automatic drive(input bit v, input bit b, input bit we,
                         input logic [MAX_W-1:0] p, input logic [LEN_W-1:0] l, input bit o,
                         output bit obs);
        @(negedge clk);
        valid = v; in = b; cfg_we = we;
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        #1;
        obs = out;
        check_eq("out", 32'(out), 32'(model_out(v, b, we)));
        @(posedge clk);
        model_step(v, b, we, p, 32'(l), o);
        #1;
`ifdef PATSEQ_COUNT_EN
        check_eq("count", 32'(count), m_cnt);
`endif
        cfg_we = 1'b0;
    endtask

    task automatic bit_in(input bit b, output bit obs);
        drive(1'b1, b, 1'b0, '0, '0, 1'b0, obs);
    endtask

    task automatic cfg(input logic [MAX_W-1:0] p, input logic [LEN_W-1:0] l, input bit o);
        bit obs;
        drive(1'b1, 1'b1, 1'b1, p, l, o, obs);
        check_eq("cfg_drop", 32'(obs), 32'd0);
    endtask

    task automatic feed(input logic [31:0] bits, input int n, output logic [31:0] hits);
        bit o;
        hits = '0;
        for (int i = 0; i < n; i++) begin
            bit_in(bits[n-1-i], o);
            hits[n-1-i] = o;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b1; in = 1'b1; cfg_we = 1'b0;
        #1;
        check_eq("out_in_rst", 32'(out), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
`ifdef PATSEQ_COUNT_EN
        check_eq("count_rst", 32'(count), 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] hits;
        bit o;
        rst = 1'b1; valid = 1'b0; in = 1'b0; cfg_we = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        model_reset();
        #1;
        check_eq("out_reset", 32'(out), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Default pattern 1011 with overlap: hits on bits 4 and 7.
        feed(32'b1011011, 7, hits);
        check_eq("ovl_stream", hits, 32'b0001001);

        // Non-overlap: single hit, then two back-to-back whole patterns.
        cfg(4'b1011, 3'd4, 1'b0);
        feed(32'b1011011, 7, hits);
        check_eq("novl_stream", hits, 32'b0001000);
        cfg(4'b1011, 3'd4, 1'b0);
        feed(32'b10111011, 8, hits);
        check_eq("novl_two", hits, 32'b00010001);

        // Invalid gap cycles hold history.
        cfg(4'b1011, 3'd4, 1'b1);
        feed(32'b10, 2, hits);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom_range(1)), 1'b0, '0, '0, 1'b0, o);
            check_eq("gap_out", 32'(o), 32'd0);
        end
        feed(32'b11, 2, hits);
        check_eq("gap_hit", hits, 32'b01);

        // Three-bit pattern with overlap.
        cfg(4'b0101, 3'd3, 1'b1);
        feed(32'b10101, 5, hits);
        check_eq("len3_stream", hits, 32'b00101);

        // Reset discards partial history.
        do_reset();
        feed(32'b101, 3, hits);
        do_reset();
        feed(32'b1, 1, hits);
        check_eq("post_rst_first", hits, 32'b0);
        feed(32'b011, 3, hits);
        check_eq("post_rst_hit", hits, 32'b001);

        // Length 0 and oversize clamp to full width; length 1 matches every bit.
        cfg(4'b1011, 3'd0, 1'b1);
        feed(32'b1011, 4, hits);
        check_eq("len0_clamp", hits, 32'b0001);
        cfg(4'b0110, 3'd7, 1'b1);
        feed(32'b0110, 4, hits);
        check_eq("len7_clamp", hits, 32'b0001);
        cfg(4'b0001, 3'd1, 1'b0);
        feed(32'b1101, 4, hits);
        check_eq("len1", hits, 32'b1101);

        // Saturation: five non-overlapping matches on a 2-bit counter.
        cfg(4'b1011, 3'd4, 1'b0);
        feed(32'hBBBBB, 20, hits);
        check_eq("sat_hits", hits, 32'h11111);
`ifdef PATSEQ_COUNT_EN
        check_eq("sat_count", 32'(count), 32'd3);
`endif

        // Random traffic with occasional reconfiguration and reset.
        for (int i = 0; i < 1500; i++) begin
            int unsigned r;
            r = $urandom_range(199);
            if (r == 0) begin
                do_reset();
            end else if (r < 4) begin
                cfg(4'($urandom), 3'($urandom), 1'($urandom));
            end else begin
                drive(($urandom_range(3) != 0), 1'($urandom), 1'b0, '0, '0, 1'b0, o);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
